// File: rtl/out_port_buffer.sv
// Output-port byte FIFO between the CPU OUT instruction and an external consumer.
// First-word-fall-through storage; a READY/HOLD pacer forces idle cycles after each handshake.
module out_port_buffer #(
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     io_write,
  input  logic [7:0]               wdata,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     drain_int
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic {READY, HOLD} state_t;

  state_t        state, state_next;
  logic [3:0]    gap_cnt, gap_cnt_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          push, pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Handshake: a byte transfers in any cycle where out_valid and out_ready are both 1;
  // out_valid never drops without such a transfer, and out_data is zero while out_valid is 0.
  always_comb begin
    out_valid = (state == READY) && !empty;
    pop       = out_valid && out_ready;
    push      = io_write && (!full || pop);
    out_data  = out_valid ? mem[rd_ptr] : 8'h00;
  end

  always_comb begin
    state_next   = state;
    gap_cnt_next = gap_cnt;
    case (state)
      READY: begin
        if (pop && (GAP > 0)) begin
          state_next   = HOLD;
          gap_cnt_next = GAP_LOAD;
        end
      end
      HOLD: begin
        // Leave HOLD the cycle after the counter has reached zero.
        if (gap_cnt == 4'd0) state_next = READY;
        else                 gap_cnt_next = gap_cnt - 4'd1;
      end
      default: state_next = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      state     <= READY;
      gap_cnt   <= 4'd0;
      overflow  <= 1'b0;
      drain_int <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      state     <= state_next;
      gap_cnt   <= gap_cnt_next;
      overflow  <= overflow | (io_write & full & ~pop);
      drain_int <= pop & ~push & (count == CW'(1));
    end
  end

  // Storage needs no reset: entries are only visible through out_data while non-empty.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: tb/tb_out_port_buffer.sv
// Randomised and directed bench for out_port_buffer: three instances (GAP 2, 0, 3) share stimulus,
// a queue-based reference model predicts each cycle, and one monitor process does all comparisons.
module tb_out_port_buffer;

  localparam int DEPTH = 4;
  localparam int NL    = 3;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic          valid;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          drn;
    logic [CW-1:0] cnt;
  } stat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          io_write;
  logic [7:0]    wdata;
  logic          out_ready;
  logic          out_valid [NL];
  logic [7:0]    out_data  [NL];
  logic          full      [NL];
  logic          empty     [NL];
  logic [CW-1:0] count     [NL];
  logic          overflow  [NL];
  logic          drain_int [NL];

  out_port_buffer #(.DEPTH(DEPTH), .GAP(2)) u_gap2 (
    .clk(clk), .rst(rst), .io_write(io_write), .wdata(wdata), .out_ready(out_ready),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .full(full[0]), .empty(empty[0]),
    .count(count[0]), .overflow(overflow[0]), .drain_int(drain_int[0]));

  out_port_buffer #(.DEPTH(DEPTH), .GAP(0)) u_gap0 (
    .clk(clk), .rst(rst), .io_write(io_write), .wdata(wdata), .out_ready(out_ready),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .full(full[1]), .empty(empty[1]),
    .count(count[1]), .overflow(overflow[1]), .drain_int(drain_int[1]));

  out_port_buffer #(.DEPTH(DEPTH), .GAP(3)) u_gap3 (
    .clk(clk), .rst(rst), .io_write(io_write), .wdata(wdata), .out_ready(out_ready),
    .out_valid(out_valid[2]), .out_data(out_data[2]), .full(full[2]), .empty(empty[2]),
    .count(count[2]), .overflow(overflow[2]), .drain_int(drain_int[2]));

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Reference model and scoreboard queues
  logic [7:0] exp_q  [NL][$];
  stat_t      stat_q [NL][$];
  logic [7:0] mq     [NL][$];
  int         hold   [NL];
  bit         ovf_m  [NL];
  bit         drn_m  [NL];

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  function automatic int gap_of(int l);
    case (l)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  // Records what each lane must show this cycle, then advances the model across the edge.
  task automatic model_cycle();
    for (int l = 0; l < NL; l++) begin
      stat_t s;
      bit    v, pop, push, is_full;
      int    sz;
      sz      = mq[l].size();
      v       = (hold[l] == 0) && (sz > 0);
      is_full = (sz == DEPTH);
      s.valid = v;
      s.full  = is_full;
      s.empty = (sz == 0);
      s.ovf   = ovf_m[l];
      s.drn   = drn_m[l];
      s.cnt   = CW'(sz);
      stat_q[l].push_back(s);
      if (rst) begin
        mq[l].delete();
        exp_q[l].delete();
        hold[l]  = 0;
        ovf_m[l] = 1'b0;
        drn_m[l] = 1'b0;
      end else begin
        pop  = v && out_ready;
        push = io_write && (!is_full || pop);
        if (pop) void'(mq[l].pop_front());
        if (push) begin
          mq[l].push_back(wdata);
          exp_q[l].push_back(wdata);
        end
        if (io_write && is_full && !pop) ovf_m[l] = 1'b1;
        drn_m[l] = pop && !push && (sz == 1);
        hold[l]  = pop ? gap_of(l) : ((hold[l] > 0) ? hold[l] - 1 : 0);
      end
    end
  endtask

  // Driver
  task automatic step(bit r, bit w, logic [7:0] d, bit rdy);
    @(negedge clk);
    #2;
    rst       = r;
    io_write  = w;
    wdata     = d;
    out_ready = rdy;
    model_cycle();
  endtask

  task automatic drain(int n);
    repeat (n) step(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin : driver
    rst = 1'b1; io_write = 1'b0; wdata = 8'h00; out_ready = 1'b0;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h33, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    // single write with consumer ready
    step(1'b0, 1'b1, 8'hA5, 1'b1);
    drain(6);
    // fill past capacity with consumer stalled
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    drain(20);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    // full with simultaneous push and pop
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
    step(1'b0, 1'b1, 8'h14, 1'b1);
    drain(20);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    // streaming through pointer wrap
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i), 1'b1);
    drain(20);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    // pacing with three preloaded bytes
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    drain(14);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    // reset while holding, overflowed, with a write in the reset cycle
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    step(1'b0, 1'b1, 8'h7E, 1'b0);
    drain(6);
    // random traffic with occasional resets
    repeat (400) begin
      step($urandom_range(0, 63) == 0, $urandom_range(0, 99) < 60,
           8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1);
    end
    drain(20);
    @(negedge clk);
    #2;
    done = 1'b1;
  end

  // Scoreboard monitor
  task automatic chk(string name, int l, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s lane%0d: got %0h expected %0h at %0t", name, l, act, exp, $time);
    end
  endtask

  initial begin : monitor
    stat_t s;
    forever begin
      @(negedge clk);
      #4;
      if (done) begin
        for (int l = 0; l < NL; l++) chk("leftover_bytes", l, exp_q[l].size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
      end
      for (int l = 0; l < NL; l++) begin
        if (stat_q[l].size() > 0) begin
          s = stat_q[l].pop_front();
          chk("out_valid", l, out_valid[l], s.valid);
          chk("full",      l, full[l],      s.full);
          chk("empty",     l, empty[l],     s.empty);
          chk("count",     l, count[l],     s.cnt);
          chk("overflow",  l, overflow[l],  s.ovf);
          chk("drain_int", l, drain_int[l], s.drn);
          if (!s.valid) chk("idle_data", l, out_data[l], 0);
        end
        if (!rst && out_valid[l] === 1'b1 && out_ready) begin
          if (exp_q[l].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected_pop lane%0d: got %0h with no byte expected at %0t",
                     l, out_data[l], $time);
          end else begin
            chk("data", l, out_data[l], exp_q[l].pop_front());
          end
        end
      end
    end
  end

endmodule

// File: doc/out_port_buffer.md
OUT_PORT_BUFFER -- requirements
Module: out_port_buffer

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries; power of two, 2..16.
REQ-002 Parameter GAP, default 2: idle cycles forced between consecutive output handshakes; 0..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 io_write  input  1  CPU write-back-stage OUT strobe, from the IO_Write control path.
REQ-006 wdata  input  8  byte written by the CPU OUT instruction (Rb value).
REQ-007 out_ready  input  1  external consumer accepts out_data this cycle.
REQ-008 out_valid  output  1  out_data holds a valid byte.
REQ-009 out_data  output  8  head-of-FIFO byte.
REQ-010 full  output  1  count == DEPTH.
REQ-011 empty  output  1  count == 0.
REQ-012 count  output  $clog2(DEPTH)+1  number of stored bytes.
REQ-013 overflow  output  1  sticky flag: a write was dropped.
REQ-014 drain_int  output  1  one-cycle pulse when the FIFO becomes empty through a pop; intended as the CPU int_sig source.

Function
REQ-015 Push occurs when io_write=1 and (full=0, or a pop occurs in the same cycle).
REQ-016 Pop occurs when out_valid=1 and out_ready=1.
REQ-017 Storage is first-word-fall-through: out_data = entry at read pointer, with zero added latency to the consumer.
REQ-018 A pushed byte appears at out_data no earlier than the cycle after the push (write-to-valid latency 1 cycle when empty and not pacing).
REQ-019 Read and write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH without extra logic.
REQ-020 count updates as follows:
- +1 on push only.
- -1 on pop only.
- unchanged on simultaneous push and pop, or on neither.
REQ-021 Simultaneous push and pop when count==1: the old byte leaves, the new byte is stored, and the FIFO remains non-empty.
REQ-022 Simultaneous push and pop when full: both are accepted, full stays 1, and overflow does not set.
REQ-023 io_write=1 while full with no pop: wdata is discarded, FIFO contents are unchanged, and overflow is set to 1.
REQ-024 overflow holds until rst.
REQ-025 The pacing FSM has two states, READY and HOLD.
REQ-026 READY: out_valid = ~empty.
REQ-027 READY -> HOLD on a pop when GAP>0; the gap counter loads GAP-1.
REQ-028 HOLD: out_valid = 0; the counter decrements each cycle; HOLD -> READY in the cycle after the counter reaches 0.
REQ-029 When GAP=0, the FSM never leaves READY, and back-to-back pops every cycle are permitted.
REQ-030 Pushes are accepted in both READY and HOLD.
REQ-031 out_data = 8'h00 whenever out_valid = 0.
REQ-032 drain_int = 1 for exactly one cycle, the cycle after a pop that moves count from 1 to 0 with no simultaneous push.
REQ-033 drain_int is not asserted on reset, and not on a push/pop pair at count 1.
REQ-034 out_valid never deasserts without a pop, except on rst.

Reset
REQ-035 In a cycle with rst=1, the following take effect at the next edge regardless of other inputs:
- pointers = 0, count = 0, FSM = READY, gap counter = 0.
- overflow = 0, drain_int = 0.
REQ-036 Outputs during and after reset: out_valid = 0, out_data = 8'h00, empty = 1, full = 0.
REQ-037 Stored array contents need no reset; they are unobservable while empty.
REQ-038 rst asserted mid-stream discards all buffered bytes and any HOLD in progress; an io_write in the same cycle is ignored.

Verification
REQ-039 Single write, DEPTH=4, GAP=2:
- Stimulus: write 8'hA5, out_ready=1.
- Response: out_valid=1 with 8'hA5 one cycle later; pop; drain_int pulses the next cycle; out_valid=0 for 2 cycles.
REQ-040 Fill to overflow:
- Stimulus: write 8'h01..8'h05 on consecutive cycles with out_ready=0.
- Response: full=1 and count=4 after the 4th write; overflow=1 after the 5th; draining yields 01,02,03,04 and 05 is lost.
REQ-041 Full with simultaneous traffic:
- Stimulus: FIFO full (10,11,12,13), GAP=0; io_write=1 with 8'h14 and out_ready=1 in the same cycle.
- Response: 10 popped, count stays 4, overflow=0; drain order is 11,12,13,14.
REQ-042 Pointer wrap-around, GAP=0:
- Stimulus: stream 8'h00..8'h0F with io_write and out_ready held high.
- Response: output order matches input order; count never exceeds 1 and never exceeds DEPTH; pointers wrap 4 times.
REQ-043 Pacing:
- Stimulus: GAP=3, 3 bytes preloaded, out_ready held 1.
- Response: pops occur on cycles t, t+4 and t+8; drain_int pulses at t+9.
REQ-044 Reset mid-operation:
- Stimulus: 3 bytes buffered, overflow=1, FSM in HOLD; assert rst for 1 cycle together with io_write=1.
- Response: count=0, empty=1, overflow=0, out_valid=0, out_data=8'h00; the next write 8'h7E appears 1 cycle later.
